// File: rtl/serial_addsub_n_if.sv
// Handshake and data bundle for serial_addsub_n.
// Master drives operands/control; slave returns status and result.
interface serial_addsub_n_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic             a_in;
  logic             b_in;
  logic             busy;
  logic             done;
  logic             s_out;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start,
    output mode,
    output a_in,
    output b_in,
    input  busy,
    input  done,
    input  s_out,
    input  out_valid,
    input  result,
    input  carry_out,
    input  overflow
  );

  modport slave (
    input  start,
    input  mode,
    input  a_in,
    input  b_in,
    output busy,
    output done,
    output s_out,
    output out_valid,
    output result,
    output carry_out,
    output overflow
  );
endinterface

// File: rtl/serial_addsub_n.sv
// Bit-serial WIDTH-bit adder/subtractor: LSB-first load,
// one full adder per clock, LSB-first shift-out.
module serial_addsub_n #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              clear,
  serial_addsub_n_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  generate
    if (WIDTH < 2) begin : g_width_chk
      $error("serial_addsub_n: WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    OUT
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_nx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic             m_q;
  logic [WIDTH-1:0] res_q;
  logic             co_q;
  logic             ov_q;

  logic last;
  logic busy;
  logic done;
  logic out_valid;
  logic fa_b;
  logic fa_s;
  logic fa_c;

  assign last   = (cnt_q == LAST);
  assign cnt_nx = last ? '0 : cnt_q + CW'(1);

  // Subtraction is A + ~B + 1: B inverted here, +1 via carry preload.
  assign fa_b = b_q[0] ^ m_q;
  assign fa_s = a_q[0] ^ fa_b ^ c_q;
  assign fa_c = (a_q[0] & fa_b)
              | (a_q[0] & c_q)
              | (fa_b & c_q);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        busy = 1'b1;
        if (last) begin
          state_d = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last) begin
          state_d = OUT;
        end
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        done      = (cnt_q == '0);
        if (last) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= 1'b0;
      m_q   <= 1'b0;
      res_q <= '0;
      co_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            m_q   <= bus.mode;
            c_q   <= bus.mode;
            cnt_q <= '0;
          end
        end
        LOAD: begin
          a_q   <= {bus.a_in, a_q[WIDTH-1:1]};
          b_q   <= {bus.b_in, b_q[WIDTH-1:1]};
          cnt_q <= cnt_nx;
        end
        CALC: begin
          a_q   <= {fa_s, a_q[WIDTH-1:1]};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          c_q   <= fa_c;
          cnt_q <= cnt_nx;
          // Last bit: c_q is the carry into the MSB.
          if (last) begin
            res_q <= {fa_s, a_q[WIDTH-1:1]};
            co_q  <= fa_c;
            ov_q  <= c_q ^ fa_c;
          end
        end
        OUT: begin
          a_q   <= {a_q[0], a_q[WIDTH-1:1]};
          cnt_q <= cnt_nx;
        end
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.out_valid = out_valid;
  assign bus.s_out     = out_valid & a_q[0];
  assign bus.result    = res_q;
  assign bus.carry_out = co_q;
  assign bus.overflow  = ov_q;

endmodule

// File: tb/tb_serial_addsub_n.sv
// Bench for serial_addsub_n: vector table + scoreboard on WIDTH=8,
// hand-written sequences for WIDTH=4, clear and back-to-back.
module tb_serial_addsub_n;

  localparam int W  = 8;
  localparam int W4 = 4;

  typedef struct {
    logic       m;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       c;
    logic       v;
  } vec_t;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       v;
    int         t0;
  } exp_t;

  logic clk = 1'b0;
  logic clear = 1'b1;
  int   cyc = 0;
  int   ntest = 0;
  int   nfail = 0;
  int   ndone8 = 0;
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_addsub_n_if #(.WIDTH(W))  b8();
  serial_addsub_n_if #(.WIDTH(W4)) b4();

  serial_addsub_n #(.WIDTH(W)) u8 (
    .clk  (clk),
    .clear(clear),
    .bus  (b8)
  );

  serial_addsub_n #(.WIDTH(W4)) u4 (
    .clk  (clk),
    .clear(clear),
    .bus  (b4)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    ntest++;
    nfail++;
    $display("FAIL %s", name);
  endtask

  function automatic vec_t model(logic m, logic [7:0] a, logic [7:0] b);
    vec_t       v;
    logic [8:0] s;
    s   = {1'b0, a} + {1'b0, (m ? ~b : b)} + 9'(m);
    v.m = m;
    v.a = a;
    v.b = b;
    v.r = s[7:0];
    v.c = s[8];
    if (m) v.v = (a[7] != b[7]) && (s[7] != a[7]);
    else   v.v = (a[7] == b[7]) && (s[7] != a[7]);
    return v;
  endfunction

  // Scoreboard / stream monitor for the WIDTH=8 instance
  exp_t       e;
  logic [7:0] st;
  int         k = 0;
  bit         act = 1'b0;

  always @(negedge clk) begin
    if (clear) begin
      act = 1'b0;
    end else begin
      if (b8.done) begin
        ndone8++;
        if (q8.size() == 0) begin
          fail("unexpected_done");
        end else begin
          e = q8.pop_front();
          chk("result", 32'(b8.result), 32'(e.r));
          chk("carry_out", 32'(b8.carry_out), 32'(e.c));
          chk("overflow", 32'(b8.overflow), 32'(e.v));
          chk("done_latency", 32'(cyc - e.t0), 32'(2 * W));
          st  = e.r;
          k   = 0;
          act = 1'b1;
        end
      end
      if (b8.out_valid) begin
        if (act && k < W) chk("s_out", 32'(b8.s_out), 32'(st[k]));
        k++;
      end else if (act) begin
        chk("out_valid_len", 32'(k), 32'(W));
        act = 1'b0;
      end
    end
  end

  task automatic wait_idle8();
    int n;
    n = 0;
    while ((q8.size() != 0 || b8.busy) && n < 4 * W) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 4 * W) begin
      fail("timeout_idle");
      q8.delete();
    end
  endtask

  task automatic load8(logic [7:0] a, logic [7:0] b);
    for (int i = 0; i < W; i++) begin
      b8.a_in = a[i];
      b8.b_in = b[i];
      @(posedge clk); #1;
    end
  endtask

  // One operation; start/mode/operand pins are scrambled during CALC.
  task automatic op8(vec_t v);
    exp_t x;
    wait_idle8();
    b8.start = 1'b1;
    b8.mode  = v.m;
    @(posedge clk); #1;
    x.r = v.r;
    x.c = v.c;
    x.v = v.v;
    x.t0 = cyc;
    q8.push_back(x);
    b8.start = 1'b0;
    b8.mode  = ~v.m;
    load8(v.a, v.b);
    for (int i = 0; i < W - 1; i++) begin
      b8.start = 1'($urandom);
      b8.mode  = 1'($urandom);
      b8.a_in  = 1'($urandom);
      b8.b_in  = 1'($urandom);
      @(posedge clk); #1;
    end
    b8.start = 1'b0;
    wait_idle8();
  endtask

  vec_t tbl[8];
  vec_t v;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] s4;
    int         n4;
    int         d4;
    int         idx;
    int         d0;
    exp_t       x;

    b8.start = 1'b1;
    b8.mode  = 1'b0;
    b8.a_in  = 1'b1;
    b8.b_in  = 1'b1;
    b4.start = 1'b0;
    b4.mode  = 1'b0;
    b4.a_in  = 1'b0;
    b4.b_in  = 1'b0;

    // start held during clear must not be accepted
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(b8.busy), 0);
    chk("rst_done", 32'(b8.done), 0);
    chk("rst_out_valid", 32'(b8.out_valid), 0);
    chk("rst_s_out", 32'(b8.s_out), 0);
    chk("rst_result", 32'(b8.result), 0);
    chk("rst_carry", 32'(b8.carry_out), 0);
    chk("rst_overflow", 32'(b8.overflow), 0);
    b8.start = 1'b0;
    clear    = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_rst", 32'(b8.busy), 0);

    tbl[0] = '{1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};

    for (int i = 0; i < 8; i++) op8(tbl[i]);
    for (int i = 0; i < 4; i++) begin
      v = model(1'($urandom), 8'($urandom), 8'($urandom));
      op8(v);
    end

    // Back-to-back: start held high, new op every 3*W+1 cycles
    d0 = ndone8;
    b8.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v = model(1'(i), 8'($urandom), 8'($urandom));
      b8.mode = v.m;
      x.r = v.r;
      x.c = v.c;
      x.v = v.v;
      x.t0 = cyc + 1;
      q8.push_back(x);
      @(posedge clk); #1;
      load8(v.a, v.b);
      repeat (2 * W) begin
        @(posedge clk); #1;
      end
    end
    b8.start = 1'b0;
    wait_idle8();
    chk("b2b_done_count", 32'(ndone8 - d0), 3);

    // clear in the middle of CALC
    b8.start = 1'b1;
    b8.mode  = 1'b0;
    @(posedge clk); #1;
    b8.start = 1'b0;
    load8(8'hC3, 8'h5A);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pre_clear_busy", 32'(b8.busy), 1);
    clear = 1'b1;
    #1;
    chk("clr_busy", 32'(b8.busy), 0);
    chk("clr_done", 32'(b8.done), 0);
    chk("clr_out_valid", 32'(b8.out_valid), 0);
    chk("clr_s_out", 32'(b8.s_out), 0);
    chk("clr_result", 32'(b8.result), 0);
    chk("clr_carry", 32'(b8.carry_out), 0);
    chk("clr_overflow", 32'(b8.overflow), 0);
    @(posedge clk); #1;
    clear = 1'b0;
    @(posedge clk); #1;
    chk("clr_idle", 32'(b8.busy), 0);
    op8('{1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0});

    // WIDTH=4: 1010 - 0011 = 0111, carry 1, signed overflow
    b4.start = 1'b1;
    b4.mode  = 1'b1;
    @(posedge clk); #1;
    b4.start = 1'b0;
    for (int i = 0; i < W4; i++) begin
      b4.a_in = 4'b1010 >> i;
      b4.b_in = 4'b0011 >> i;
      @(posedge clk); #1;
    end
    s4  = '0;
    n4  = 0;
    d4  = 0;
    idx = 0;
    for (int i = 0; i < 4 * W4; i++) begin
      if (b4.done) begin
        d4++;
        chk("w4_result", 32'(b4.result), 32'(4'b0111));
        chk("w4_carry", 32'(b4.carry_out), 1);
        chk("w4_overflow", 32'(b4.overflow), 1);
      end
      if (b4.out_valid) begin
        n4++;
        if (idx < W4) s4[idx] = b4.s_out;
        idx++;
      end
      @(posedge clk); #1;
    end
    chk("w4_done_pulses", 32'(d4), 1);
    chk("w4_out_valid_len", 32'(n4), 32'(W4));
    chk("w4_stream", 32'(s4), 32'(4'b0111));
    chk("w4_idle", 32'(b4.busy), 0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
